// File: rtl/draw_axi_vram_slave_if.sv
// AXI4 write/read channel bundle between the draw engine master and the VRAM responder.
// Fixed INCR, 4-byte beats, so burst type and size are not carried.
interface draw_axi_vram_slave_if;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );
endinterface

// File: rtl/draw_axi_vram_slave.sv
// AXI4 INCR-burst VRAM responder: byte-strobed word memory with independent write and read FSMs.
// state   | meaning
// W_IDLE  | AWREADY high, waiting for a write burst
// W_DATA  | WREADY high, accepting beats until count == len
// W_RESP  | BVALID high until BREADY
// R_IDLE  | ARREADY high, waiting for a read burst
// R_FETCH | word index presented to the RAM
// R_DATA  | RVALID high, beat held until RREADY
module draw_axi_vram_slave #(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  ARST,
  draw_axi_vram_slave_if.slave  s_axi,
  output logic                  WR_BUSY,
  output logic                  RD_BUSY,
  output logic                  PROTO_ERR
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

  // Addresses are carried in 33 bits so a burst running past 4 GiB never wraps back into the window.
  function automatic logic in_window(input logic [32:0] addr);
    logic [32:0] off;
    off = addr - {1'b0, BASE_ADDR};
    return (addr >= {1'b0, BASE_ADDR}) && ((off >> (DEPTH_LOG2 + 2)) == 33'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [32:0] addr);
    logic [32:0] off;
    off = addr - {1'b0, BASE_ADDR};
    return DEPTH_LOG2'(off >> 2);
  endfunction

  wr_state_t   wr_state;
  logic [32:0] waddr;
  logic [7:0]  wlen, wcnt;
  logic        werr;
  logic        awready, wready, bvalid;
  logic [1:0]  bresp;
  logic        w_fire, w_inwin, w_last_beat;

  rd_state_t   rd_state;
  logic [32:0] raddr;
  logic [7:0]  rlen, rcnt;
  logic        arready, rvalid, rlast;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        r_inwin;

  logic [31:0] mem [DEPTH];

  assign w_fire      = wready && s_axi.S_AXI_WVALID;
  assign w_inwin     = in_window(waddr);
  assign w_last_beat = (wcnt == wlen);
  assign r_inwin     = in_window(raddr);

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RLAST   = rlast;
  assign s_axi.S_AXI_RDATA   = rdata;

  // Memory array has no reset so contents survive an ARST pulse.
  always_ff @(posedge CLK) begin
    if (w_fire && w_inwin && !ARST) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi.S_AXI_WSTRB[i])
          mem[word_idx(waddr)][8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ARST)
      rdata <= '0;
    else if (rd_state == R_FETCH)
      rdata <= r_inwin ? mem[word_idx(raddr)] : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      wr_state  <= W_IDLE;
      waddr     <= '0;
      wlen      <= '0;
      wcnt      <= '0;
      werr      <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      WR_BUSY   <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && s_axi.S_AXI_AWVALID) begin
            waddr    <= {1'b0, s_axi.S_AXI_AWADDR};
            wlen     <= s_axi.S_AXI_AWLEN;
            wcnt     <= '0;
            werr     <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b1;
            WR_BUSY  <= 1'b1;
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (!w_inwin)
              werr <= 1'b1;
            if (s_axi.S_AXI_WLAST != w_last_beat)
              PROTO_ERR <= 1'b1;
            // The beat count, not WLAST, terminates the burst.
            if (w_last_beat) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (werr || !w_inwin) ? 2'b10 : 2'b00;
              wr_state <= W_RESP;
            end else begin
              waddr <= waddr + 33'd4;
              wcnt  <= wcnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            awready  <= 1'b1;
            WR_BUSY  <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      rd_state <= R_IDLE;
      raddr    <= '0;
      rlen     <= '0;
      rcnt     <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= 2'b00;
      RD_BUSY  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && s_axi.S_AXI_ARVALID) begin
            raddr    <= {1'b0, s_axi.S_AXI_ARADDR};
            rlen     <= s_axi.S_AXI_ARLEN;
            rcnt     <= '0;
            arready  <= 1'b0;
            RD_BUSY  <= 1'b1;
            rd_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid   <= 1'b1;
          rresp    <= r_inwin ? 2'b00 : 2'b10;
          rlast    <= (rcnt == rlen);
          rd_state <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              rresp    <= 2'b00;
              arready  <= 1'b1;
              RD_BUSY  <= 1'b0;
              rd_state <= R_IDLE;
            end else begin
              raddr    <= raddr + 33'd4;
              rcnt     <= rcnt + 8'd1;
              rd_state <= R_FETCH;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_axi_vram_slave.sv
// Directed bench for draw_axi_vram_slave: 256-word window at 0x0001_0000, checks at each negedge.
module tb_draw_axi_vram_slave;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic CLK = 1'b0;
  logic ARST;
  logic WR_BUSY, RD_BUSY, PROTO_ERR;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [1:0] resp;

  draw_axi_vram_slave_if bus ();

  draw_axi_vram_slave #(.DEPTH_LOG2(8), .BASE_ADDR(BASE)) dut (
    .CLK       (CLK),
    .ARST      (ARST),
    .s_axi     (bus.slave),
    .WR_BUSY   (WR_BUSY),
    .RD_BUSY   (RD_BUSY),
    .PROTO_ERR (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beats carry d0+i; lastbeat<0 means WLAST on beat len; nbeats<len+1 leaves the burst unfinished.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                           input logic [3:0] strb, input int nbeats, input int lastbeat,
                           input int gapmax, input int bdelay, output logic [1:0] bresp_o);
    int n;
    int g;
    bresp_o = 2'b00;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = len;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge CLK); n++; end
    check("aw_wait", n < 50, 1);
    @(negedge CLK);
    bus.S_AXI_AWVALID = 1'b0;
    check("aw_to_w", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b01);
    for (int i = 0; i < nbeats; i++) begin
      if (gapmax > 0) begin
        g = $urandom_range(0, gapmax);
        repeat (g) @(negedge CLK);
      end
      bus.S_AXI_WDATA  = d0 + i;
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = (lastbeat >= 0) ? (i == lastbeat) : (i == int'(len));
      bus.S_AXI_WVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_WREADY && n < 50) begin @(negedge CLK); n++; end
      check("w_wait", n < 50, 1);
      @(negedge CLK);
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_WLAST  = 1'b0;
      check("w_after_beat", {bus.S_AXI_WREADY, bus.S_AXI_BVALID},
            (i == int'(len)) ? 2'b01 : 2'b10);
    end
    if (nbeats == int'(len) + 1) begin
      bus.S_AXI_BREADY = 1'b0;
      n = 0;
      while (!bus.S_AXI_BVALID && n < 50) begin @(negedge CLK); n++; end
      check("b_wait", n < 50, 1);
      for (int k = 0; k < bdelay; k++) begin
        check("b_hold", bus.S_AXI_BVALID, 1);
        @(negedge CLK);
      end
      bresp_o = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge CLK);
      bus.S_AXI_BREADY = 1'b0;
      check("b_done", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 2'b01);
    end
  endtask

  // Beats below nvalid expect d0+i / OKAY, the rest 0 / SLVERR.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                          input int nvalid, input bit toggle);
    int n;
    logic [31:0] held;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge CLK); n++; end
    check("ar_wait", n < 50, 1);
    @(negedge CLK);
    bus.S_AXI_ARVALID = 1'b0;
    check("r_fetch", {bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 2'b00);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!bus.S_AXI_RVALID && n < 50) begin @(negedge CLK); n++; end
      check("r_latency", n, 1);
      if (toggle && (i % 2 == 0)) begin
        held = bus.S_AXI_RDATA;
        @(negedge CLK);
        check("r_hold_valid", bus.S_AXI_RVALID, 1);
        check("r_hold_data", bus.S_AXI_RDATA, held);
      end
      check("r_data", bus.S_AXI_RDATA, (i < nvalid) ? d0 + i : 32'h0);
      check("r_resp", bus.S_AXI_RRESP, (i < nvalid) ? 2'b00 : 2'b10);
      check("r_last", bus.S_AXI_RLAST, i == int'(len));
      bus.S_AXI_RREADY = 1'b1;
      @(negedge CLK);
      bus.S_AXI_RREADY = 1'b0;
      check("r_after", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY},
            (i == int'(len)) ? 2'b01 : 2'b00);
    end
  endtask

  initial begin
    int n;
    ARST = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge CLK);

    check("rst_ctrl", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                       bus.S_AXI_RVALID, bus.S_AXI_RLAST, WR_BUSY, RD_BUSY, PROTO_ERR}, 9'h000);
    check("rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'h0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    ARST = 1'b0;
    @(negedge CLK);
    check("rst_release", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);

    // Basic 4-beat write and readback
    axi_write(BASE + 32'h100, 8'd3, 32'h0000_00A0, 4'hF, 4, -1, 0, 0, resp);
    check("t1_bresp", resp, 2'b00);
    axi_read(BASE + 32'h100, 8'd3, 32'h0000_00A0, 4, 1'b0);

    // Byte strobes
    axi_write(BASE, 8'd0, 32'hFFFF_FFFF, 4'hF, 1, -1, 0, 0, resp);
    axi_write(BASE, 8'd0, 32'h1234_5678, 4'b0101, 1, -1, 0, 0, resp);
    check("t2_bresp", resp, 2'b00);
    axi_read(BASE, 8'd0, 32'hFF34_FF78, 1, 1'b0);

    // Full-depth burst with W gaps, delayed BREADY, readback with RREADY stalls
    axi_write(BASE, 8'd255, 32'hC0DE_0000, 4'hF, 256, -1, 2, 5, resp);
    check("t3_bresp", resp, 2'b00);
    axi_read(BASE, 8'd255, 32'hC0DE_0000, 256, 1'b1);

    // Burst crossing the window top: last two beats dropped, no aliasing onto words 0-1
    axi_write(BASE + 32'h3F8, 8'd3, 32'h0000_00B0, 4'hF, 4, -1, 0, 0, resp);
    check("t4_bresp", resp, 2'b10);
    axi_read(BASE + 32'h3F8, 8'd3, 32'h0000_00B0, 2, 1'b0);
    axi_read(BASE, 8'd1, 32'hC0DE_0000, 2, 1'b0);

    // Early WLAST: burst still runs four beats and the sticky flag latches
    check("t5_perr_before", PROTO_ERR, 1'b0);
    axi_write(BASE + 32'h80, 8'd3, 32'h0000_00E0, 4'hF, 4, 1, 0, 0, resp);
    check("t5_bresp", resp, 2'b00);
    check("t5_perr_after", PROTO_ERR, 1'b1);
    axi_read(BASE + 32'h80, 8'd3, 32'h0000_00E0, 4, 1'b0);

    // Reset during an open read and a half-written burst
    bus.S_AXI_ARADDR = BASE + 32'h200;
    bus.S_AXI_ARLEN = 8'd3;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge CLK); n++; end
    @(negedge CLK);
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge CLK);
    check("t6_rvalid_open", {bus.S_AXI_RVALID, RD_BUSY}, 2'b11);
    axi_write(BASE + 32'h40, 8'd7, 32'h0000_00D0, 4'hF, 2, -1, 0, 0, resp);
    check("t6_mid_burst", {WR_BUSY, PROTO_ERR, bus.S_AXI_RVALID}, 3'b111);
    ARST = 1'b1;
    @(negedge CLK);
    check("t6_in_reset", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                          bus.S_AXI_RVALID, WR_BUSY, RD_BUSY, PROTO_ERR}, 8'h00);
    ARST = 1'b0;
    @(negedge CLK);
    check("t6_released", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID}, 3'b110);
    repeat (3) @(negedge CLK);
    check("t6_no_bvalid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    axi_read(BASE + 32'h40, 8'd1, 32'h0000_00D0, 2, 1'b0);
    axi_read(BASE + 32'h48, 8'd0, 32'hC0DE_0012, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
